// File: rtl/ddram_arb_if.sv
// rtl/ddram_arb_if.sv - DDRAM port-A arbiter bus: clear, host and glyph-refresh requesters, write port

interface ddram_arb_if #(
    parameter int DATA_W = 64
);
    logic              ClrReqY;
    logic              HostReqY;
    logic [6:0]        HostAdrY;
    logic [DATA_W-1:0] HostDataY;
    logic              HostAckQ;
    logic              CgReqY;
    logic [6:0]        CgAdrY;
    logic [DATA_W-1:0] CgDataY;
    logic              CgAckQ;
    logic [5:0]        AdrQ;
    logic [DATA_W-1:0] DataQ;
    logic              WrUpQ;
    logic              WrDwQ;
    logic              BusyQ;
    logic              ErrQ;

    modport master (
        output ClrReqY, HostReqY, HostAdrY, HostDataY, CgReqY, CgAdrY, CgDataY,
        input  HostAckQ, CgAckQ, AdrQ, DataQ, WrUpQ, WrDwQ, BusyQ, ErrQ
    );

    modport slave (
        input  ClrReqY, HostReqY, HostAdrY, HostDataY, CgReqY, CgAdrY, CgDataY,
        output HostAckQ, CgAckQ, AdrQ, DataQ, WrUpQ, WrDwQ, BusyQ, ErrQ
    );
endinterface

// File: rtl/ddram_arb.sv
// rtl/ddram_arb.sv - DDRAM port-A write arbiter with clear sweep; DDRAM_ARB_FAIR_EN selects round-robin
// Without DDRAM_ARB_FAIR_EN the host always wins a tie over the glyph-refresh engine.

module ddram_arb #(
    parameter int WORDS  = 40,
    parameter int DATA_W = 64
) (
    input logic       C,
    input logic       naR,
    ddram_arb_if.slave bus
);

    localparam logic [6:0] WORDS_L = 7'(WORDS);
    localparam logic [5:0] LAST    = 6'(WORDS - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [5:0]        cnt;
    logic              pick_host;
    logic              any_req;
    logic              grant_host;
    logic              adr_ok;
    logic [6:0]        sel_adr;
    logic [DATA_W-1:0] sel_data;

`ifdef DDRAM_ARB_FAIR_EN
    // High when the glyph-refresh engine held the last grant, so the host wins the next tie.
    logic last_cg;
`endif

    always_comb begin
`ifdef DDRAM_ARB_FAIR_EN
        pick_host = last_cg;
`else
        pick_host = 1'b1;
`endif
        any_req    = bus.HostReqY | bus.CgReqY;
        grant_host = bus.HostReqY & (~bus.CgReqY | pick_host);
        sel_adr    = grant_host ? bus.HostAdrY  : bus.CgAdrY;
        sel_data   = grant_host ? bus.HostDataY : bus.CgDataY;
        adr_ok     = {1'b0, sel_adr[5:0]} < WORDS_L;
    end

    // cnt holds the next sweep address; the first word is written on the edge that sees ClrReqY.
    always_ff @(posedge C or negedge naR) begin
        if (!naR) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.HostAckQ <= 1'b0;
            bus.CgAckQ   <= 1'b0;
            bus.AdrQ     <= '0;
            bus.DataQ    <= '0;
            bus.WrUpQ    <= 1'b0;
            bus.WrDwQ    <= 1'b0;
            bus.BusyQ    <= 1'b0;
            bus.ErrQ     <= 1'b0;
`ifdef DDRAM_ARB_FAIR_EN
            last_cg      <= 1'b1;
`endif
        end else begin
            bus.HostAckQ <= 1'b0;
            bus.CgAckQ   <= 1'b0;
            bus.WrUpQ    <= 1'b0;
            bus.WrDwQ    <= 1'b0;
            bus.BusyQ    <= 1'b0;
            if (bus.ClrReqY) begin
                bus.AdrQ  <= '0;
                bus.DataQ <= '0;
                bus.WrUpQ <= 1'b1;
                bus.WrDwQ <= 1'b1;
                bus.BusyQ <= 1'b1;
                bus.ErrQ  <= 1'b0;
                if (LAST == 6'd0) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    state <= CLEAR;
                    cnt   <= 6'd1;
                end
            end else if (state == CLEAR) begin
                bus.AdrQ  <= cnt;
                bus.DataQ <= '0;
                bus.WrUpQ <= 1'b1;
                bus.WrDwQ <= 1'b1;
                bus.BusyQ <= 1'b1;
                if (cnt == LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 6'd1;
                end
            end else if (any_req) begin
                bus.HostAckQ <= grant_host;
                bus.CgAckQ   <= ~grant_host;
                bus.AdrQ     <= sel_adr[5:0];
                bus.DataQ    <= sel_data;
                if (adr_ok) begin
                    bus.WrUpQ <= ~sel_adr[6];
                    bus.WrDwQ <= sel_adr[6];
                end else begin
                    bus.ErrQ <= 1'b1;
                end
`ifdef DDRAM_ARB_FAIR_EN
                last_cg <= ~grant_host;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ddram_arb.sv
// tb/tb_ddram_arb.sv - self-checking bench for ddram_arb with directed scenarios and a randomized reference model

module tb_ddram_arb;

    localparam int WORDS  = 40;
    localparam int DATA_W = 64;
    localparam int VW     = DATA_W + 12;

    logic C;
    logic naR;
    int   n_cmp;
    int   n_err;

    ddram_arb_if #(.DATA_W(DATA_W)) ifc ();

    ddram_arb #(.WORDS(WORDS), .DATA_W(DATA_W)) dut (
        .C   (C),
        .naR (naR),
        .bus (ifc.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // Reference model state: remaining sweep words, next sweep word, sticky error, last grant, held port.
    int                m_left;
    int                m_sweep;
    bit                m_err;
    bit                m_last_cg;
    logic [5:0]        m_adr;
    logic [DATA_W-1:0] m_data;
    logic [VW-1:0]     m_exp;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic drive_idle();
        ifc.ClrReqY   = 1'b0;
        ifc.HostReqY  = 1'b0;
        ifc.HostAdrY  = '0;
        ifc.HostDataY = '0;
        ifc.CgReqY    = 1'b0;
        ifc.CgAdrY    = '0;
        ifc.CgDataY   = '0;
    endtask

    function automatic logic [VW-1:0] outs();
        return {ifc.HostAckQ, ifc.CgAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ, ifc.ErrQ, ifc.AdrQ, ifc.DataQ};
    endfunction

    task automatic model_reset();
        m_left    = 0;
        m_sweep   = 0;
        m_err     = 1'b0;
        m_last_cg = 1'b1;
        m_adr     = '0;
        m_data    = '0;
    endtask

    // Expected outputs after the next edge, derived from the rules for sweep, grant and range check.
    task automatic model_step();
        bit hack, cack, wu, wd, busy, host_wins;
        int word;
        hack = 0; cack = 0; wu = 0; wd = 0; busy = 0;
        if (ifc.ClrReqY) begin
            m_left  = WORDS;
            m_sweep = 0;
            m_err   = 1'b0;
        end
        if (m_left > 0) begin
            m_adr  = 6'(m_sweep);
            m_data = '0;
            wu = 1; wd = 1; busy = 1;
            m_sweep++;
            m_left--;
        end else if (ifc.HostReqY || ifc.CgReqY) begin
`ifdef DDRAM_ARB_FAIR_EN
            host_wins = ifc.HostReqY && (!ifc.CgReqY || m_last_cg);
`else
            host_wins = ifc.HostReqY;
`endif
            hack      = host_wins;
            cack      = !host_wins;
            m_last_cg = !host_wins;
            m_adr     = host_wins ? ifc.HostAdrY[5:0] : ifc.CgAdrY[5:0];
            m_data    = host_wins ? ifc.HostDataY : ifc.CgDataY;
            word      = int'(m_adr);
            if (word < WORDS) begin
                if ((host_wins ? ifc.HostAdrY[6] : ifc.CgAdrY[6]) == 1'b0) wu = 1;
                else wd = 1;
            end else begin
                m_err = 1'b1;
            end
        end
        m_exp = {hack, cack, wu, wd, busy, m_err, m_adr, m_data};
    endtask

    task automatic test_reset();
        drive_idle();
        naR = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", outs());
        end
        tick();
        tick();
        #2 naR = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ, ifc.HostAckQ, ifc.CgAckQ} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_idle_quiet: got %b expected 00000",
                     {ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ, ifc.HostAckQ, ifc.CgAckQ});
        end
    endtask

    task automatic test_clear_sweep();
        int bad;
        bad = 0;
        ifc.ClrReqY = 1'b1;
        tick();
        ifc.ClrReqY = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            if (!(ifc.WrUpQ === 1'b1 && ifc.WrDwQ === 1'b1 && ifc.BusyQ === 1'b1 &&
                  ifc.DataQ === '0 && ifc.AdrQ === 6'(i))) begin
                bad++;
                $display("FAIL clear_sweep_word: word %0d got adr=%0d up=%b dw=%b busy=%b data=%h",
                         i, ifc.AdrQ, ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ, ifc.DataQ);
            end
            tick();
        end
        n_cmp++;
        if (bad != 0) n_err++;
        n_cmp++;
        if ({ifc.BusyQ, ifc.WrUpQ, ifc.WrDwQ} !== 3'b000) begin
            n_err++;
            $display("FAIL clear_sweep_end: got busy/up/dw=%b expected 000", {ifc.BusyQ, ifc.WrUpQ, ifc.WrDwQ});
        end
    endtask

    task automatic test_host_write();
        ifc.HostReqY  = 1'b1;
        ifc.HostAdrY  = 7'h45;
        ifc.HostDataY = 64'hA5;
        tick();
        ifc.HostReqY = 1'b0;
        n_cmp++;
        if ({ifc.HostAckQ, ifc.CgAckQ, ifc.WrDwQ, ifc.WrUpQ, ifc.AdrQ, ifc.DataQ} !==
            {4'b1010, 6'd5, 64'hA5}) begin
            n_err++;
            $display("FAIL host_write: got ack=%b up=%b dw=%b adr=%0d data=%h expected ack=1 up=0 dw=1 adr=5 data=a5",
                     ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.AdrQ, ifc.DataQ);
        end
        tick();
        n_cmp++;
        if ({ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.AdrQ, ifc.DataQ} !== {3'b000, 6'd5, 64'hA5}) begin
            n_err++;
            $display("FAIL host_write_hold: got ack=%b up=%b dw=%b adr=%0d data=%h expected 0 0 0 5 a5",
                     ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.AdrQ, ifc.DataQ);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_seq [4];
`ifdef DDRAM_ARB_FAIR_EN
        exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        naR = 1'b0;
        #2 naR = 1'b1;
        ifc.HostReqY  = 1'b1;
        ifc.HostAdrY  = 7'h01;
        ifc.HostDataY = 64'h1111;
        ifc.CgReqY    = 1'b1;
        ifc.CgAdrY    = 7'h42;
        ifc.CgDataY   = 64'h2222;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({ifc.HostAckQ, ifc.CgAckQ} !== exp_seq[i]) begin
                n_err++;
                $display("FAIL arb_grant_%0d: got host/cg ack=%b expected %b", i, {ifc.HostAckQ, ifc.CgAckQ}, exp_seq[i]);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_err();
        ifc.HostReqY = 1'b1;
        ifc.HostAdrY = 7'h28;
        tick();
        ifc.HostReqY = 1'b0;
        n_cmp++;
        if ({ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.ErrQ} !== 4'b1001) begin
            n_err++;
            $display("FAIL err_set: got ack/up/dw/err=%b expected 1001", {ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.ErrQ});
        end
        ifc.CgReqY = 1'b1;
        ifc.CgAdrY = 7'h03;
        tick();
        ifc.CgReqY = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (ifc.ErrQ !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %b expected 1", ifc.ErrQ);
        end
        ifc.ClrReqY = 1'b1;
        tick();
        ifc.ClrReqY = 1'b0;
        n_cmp++;
        if (ifc.ErrQ !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got %b expected 0", ifc.ErrQ);
        end
        for (int i = 0; i < WORDS; i++) tick();
    endtask

    task automatic test_clear_restart();
        int bad;
        bad = 0;
        ifc.ClrReqY = 1'b1;
        tick();
        ifc.ClrReqY = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (ifc.AdrQ !== 6'd20 || ifc.BusyQ !== 1'b1) begin
            n_err++;
            $display("FAIL restart_reach20: got adr=%0d busy=%b expected 20 1", ifc.AdrQ, ifc.BusyQ);
        end
        ifc.ClrReqY   = 1'b1;
        ifc.HostReqY  = 1'b1;
        ifc.HostAdrY  = 7'h03;
        ifc.HostDataY = 64'hDEAD_BEEF;
        tick();
        ifc.ClrReqY = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            if (ifc.AdrQ !== 6'(i) || ifc.BusyQ !== 1'b1 || ifc.HostAckQ !== 1'b0) begin
                bad++;
                $display("FAIL restart_word: word %0d got adr=%0d busy=%b ack=%b", i, ifc.AdrQ, ifc.BusyQ, ifc.HostAckQ);
            end
            tick();
        end
        n_cmp++;
        if (bad != 0) n_err++;
        ifc.HostReqY = 1'b0;
        n_cmp++;
        if ({ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ, ifc.AdrQ, ifc.DataQ} !==
            {4'b1100, 6'd3, 64'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL restart_host_ack: got ack=%b up=%b dw=%b busy=%b adr=%0d data=%h",
                     ifc.HostAckQ, ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ, ifc.AdrQ, ifc.DataQ);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int bad;
        bad = 0;
        ifc.ClrReqY = 1'b1;
        tick();
        ifc.ClrReqY = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (ifc.AdrQ !== 6'd10) begin
            n_err++;
            $display("FAIL midreset_reach10: got adr=%0d expected 10", ifc.AdrQ);
        end
        #1 naR = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h expected 0", outs());
        end
        tick();
        #2 naR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if ({ifc.WrUpQ, ifc.WrDwQ, ifc.BusyQ} !== 3'b000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midreset_no_writes: %0d cycles with activity, expected 0", bad);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        naR = 1'b0;
        drive_idle();
        #2 naR = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ifc.ClrReqY   = ($urandom_range(0, 39) == 0);
            ifc.HostReqY  = ($urandom_range(0, 2) != 0);
            ifc.HostAdrY  = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 44))};
            ifc.HostDataY = {$urandom, $urandom};
            ifc.CgReqY    = ($urandom_range(0, 2) != 0);
            ifc.CgAdrY    = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 44))};
            ifc.CgDataY   = {$urandom, $urandom};
            model_step();
            tick();
            n_cmp++;
            if (outs() !== m_exp) begin
                n_err++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle_%0d: got %h expected %h", cyc, outs(), m_exp);
            end
        end
        drive_idle();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        naR   = 1'b0;
        drive_idle();
        test_reset();
        test_clear_sweep();
        test_host_write();
        test_arbitration();
        test_err();
        test_clear_restart();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddram_arb.md
DDRAM_ARB -- requirements
Module: ddram_arb

Interface
REQ-001 Parameter WORDS, default 40: DDRAM words per bank; valid addresses are 0..WORDS-1.
REQ-002 Parameter DATA_W, default 64: width of one glyph-column word.
REQ-003 C  input  1  clock, 390.625 kHz display domain, rising edge.
REQ-004 naR  input  1  reset, asynchronous, active-low.
REQ-005 ClrReqY  input  1  one-cycle pulse; starts a clear sweep of both banks.
REQ-006 HostReqY  input  1  host write request; level, held until HostAckQ.
REQ-007 HostAdrY  input  7  host address: [6] bank (0 up, 1 down), [5:0] word.
REQ-008 HostDataY  input  DATA_W  host write data.
REQ-009 HostAckQ  output  1  one-cycle grant pulse for the host.
REQ-010 CgReqY  input  1  glyph-refresh engine write request; level, held until CgAckQ.
REQ-011 CgAdrY  input  7  glyph-refresh address, same format as HostAdrY.
REQ-012 CgDataY  input  DATA_W  glyph-refresh write data.
REQ-013 CgAckQ  output  1  one-cycle grant pulse for the glyph-refresh engine.
REQ-014 AdrQ  output  6  DDRAM port-A word address.
REQ-015 DataQ  output  DATA_W  DDRAM port-A write data.
REQ-016 WrUpQ  output  1  write strobe, upper bank.
REQ-017 WrDwQ  output  1  write strobe, lower bank.
REQ-018 BusyQ  output  1  clear sweep in progress; doubles as busy-flag source.
REQ-019 ErrQ  output  1  sticky out-of-range address flag.

Function
REQ-020 FSM states: IDLE, CLEAR. All outputs SHALL be registered.
REQ-021 IDLE: ClrReqY SHALL enter CLEAR with sweep counter 0; it takes precedence over any pending request in the same cycle.
REQ-022 CLEAR: each cycle SHALL drive AdrQ=counter, DataQ=0, WrUpQ=WrDwQ=1, then increment; after word WORDS-1 is written, return to IDLE.
REQ-023 A clear sweep SHALL take exactly WORDS cycles, with BusyQ high on exactly those WORDS cycles.
REQ-024 ClrReqY during CLEAR SHALL restart the counter at 0; BusyQ stays high.
REQ-025 No ack SHALL be issued during CLEAR; requests stay pending and are serviced after return to IDLE.
REQ-026 IDLE with at least one request: exactly one requester SHALL be granted per cycle; its ack, AdrQ, DataQ and write strobe appear together on the next rising edge (latency 1).
REQ-027 The strobe SHALL follow bank bit [6]: 0 gives WrUpQ, 1 gives WrDwQ; never both outside CLEAR.
REQ-028 Word address at or above WORDS: ack SHALL still be issued, no strobe asserted, ErrQ set to 1.
REQ-029 ErrQ SHALL clear only on reset or on ClrReqY.
REQ-030 After an ack, the requester is expected to drop or change its request; the same request still held SHALL be treated as a new request.
REQ-031 With no grant and not in CLEAR: WrUpQ=WrDwQ=0 and ack outputs 0; AdrQ and DataQ hold their last values.
REQ-032 Tie-break follows REQ-036 and REQ-037; a single requester SHALL always be granted the next cycle.

Reset
REQ-033 naR low SHALL asynchronously force: IDLE, counter 0, all outputs 0, last-grant pointer = Cg.
REQ-034 Reset mid-sweep SHALL abort the sweep; after release the block is in IDLE and waits for a new ClrReqY.

Configuration
REQ-035 Macro DDRAM_ARB_FAIR_EN selects the arbitration scheme.
REQ-036 Macro defined: round-robin between Host and Cg; on a tie, grant the one not granted last; the pointer updates on each ack.
REQ-037 Macro undefined: fixed priority, Host over Cg; the pointer is not implemented.

Verification
REQ-038 Release reset, pulse ClrReqY -> 40 consecutive cycles of WrUpQ=WrDwQ=1, DataQ=0, AdrQ 0..39; BusyQ high exactly those 40 cycles.
REQ-039 HostReqY with HostAdrY=7'h45 and data 64'hA5 -> next edge: HostAckQ=1, WrDwQ=1, WrUpQ=0, AdrQ=5, DataQ=64'hA5.
REQ-040 HostReqY and CgReqY held together for 4 grants -> FAIR_EN: acks Host, Cg, Host, Cg; no macro: Host on all four.
REQ-041 HostAdrY=7'h28 (word 40) -> HostAckQ=1, no strobe, ErrQ=1; ErrQ stays 1 until ClrReqY.
REQ-042 ClrReqY at sweep address 20, HostReqY pending -> sweep restarts at 0 and runs 40 more cycles; HostAckQ arrives on the cycle after the final clear write.
REQ-043 naR low at sweep address 10 -> all outputs 0 immediately; after release no writes occur until the next request.
